// File: rtl/spi_slave_param_if.sv
// Bus bundle for spi_slave_param: SPI pins plus the memory-side rx/tx handshake.
interface spi_slave_param_if #(
  parameter int unsigned DATA_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic              rx_err;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, rx_err
  );

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, rx_err
  );
endinterface

// File: rtl/spi_slave_param.sv
// SPI slave: command decode, DATA_W+2-bit frame receive, and read-data transmit on MISO.
// Define SPI_PARITY_EN to append an odd-parity bit to every received frame.
module spi_slave_param #(
  parameter int unsigned DATA_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  spi_slave_param_if.slave bus
);
  localparam int unsigned FrameW = DATA_W + 2;
`ifdef SPI_PARITY_EN
  localparam int unsigned ShW     = FrameW;
  localparam int unsigned LastIdx = FrameW;
`else
  localparam int unsigned ShW     = FrameW - 1;
  localparam int unsigned LastIdx = FrameW - 1;
`endif
  localparam int unsigned CntW   = $clog2(LastIdx + 1);
  localparam int unsigned TxCntW = $clog2(DATA_W + 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StChkCmd   = 3'd1;
  localparam logic [2:0] StWrite    = 3'd2;
  localparam logic [2:0] StReadAdd  = 3'd3;
  localparam logic [2:0] StReadData = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ShW-1:0]    shift_q, shift_d;
  logic              done_q, done_d;
  logic [FrameW-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              addr_rcvd_q, addr_rcvd_d;
  logic              tx_wait_q, tx_wait_d;
  logic              tx_busy_q, tx_busy_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [TxCntW-1:0] tx_cnt_q, tx_cnt_d;
  logic              miso_q, miso_d;
`ifdef SPI_PARITY_EN
  logic              rx_err_q, rx_err_d;
`endif

  logic              last_bit;
  logic [FrameW-1:0] frame;
  logic              frame_ok;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    done_d      = done_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    addr_rcvd_d = addr_rcvd_q;
    tx_wait_d   = tx_wait_q;
    tx_busy_d   = tx_busy_q;
    tx_shift_d  = tx_shift_q;
    tx_cnt_d    = tx_cnt_q;
    miso_d      = 1'b0;
`ifdef SPI_PARITY_EN
    rx_err_d    = 1'b0;
    frame       = shift_q;
    frame_ok    = ^{shift_q, bus.MOSI};
`else
    frame       = {shift_q, bus.MOSI};
    frame_ok    = 1'b1;
`endif
    last_bit    = (cnt_q == CntW'(LastIdx));

    case (state_q)
      StIdle: begin
        cnt_d  = '0;
        done_d = 1'b0;
        if (!bus.SS_n) state_d = StChkCmd;
      end
      StChkCmd: begin
        cnt_d  = '0;
        done_d = 1'b0;
        if (bus.SS_n)         state_d = StIdle;
        else if (!bus.MOSI)   state_d = StWrite;
        else if (addr_rcvd_q) state_d = StReadData;
        else                  state_d = StReadAdd;
      end
      StWrite, StReadAdd, StReadData: begin
        if (!done_q && last_bit) begin
          // Last bit still counts when SS_n rises on the same cycle.
          done_d = 1'b1;
          cnt_d  = '0;
          if (frame_ok) begin
            rx_data_d  = frame;
            rx_valid_d = 1'b1;
            if (state_q == StReadAdd) addr_rcvd_d = 1'b1;
            if (state_q == StReadData && !bus.SS_n) tx_wait_d = 1'b1;
          end
`ifdef SPI_PARITY_EN
          if (!frame_ok) rx_err_d = 1'b1;
`endif
          if (bus.SS_n) state_d = StIdle;
        end else if (bus.SS_n) begin
          state_d    = StIdle;
          cnt_d      = '0;
          done_d     = 1'b0;
          tx_wait_d  = 1'b0;
          tx_busy_d  = 1'b0;
          tx_shift_d = '0;
          tx_cnt_d   = '0;
        end else if (!done_q) begin
          shift_d = {shift_q[ShW-2:0], bus.MOSI};
          cnt_d   = cnt_q + CntW'(1);
        end else if (tx_wait_q && bus.tx_valid) begin
          tx_wait_d  = 1'b0;
          tx_busy_d  = 1'b1;
          miso_d     = bus.tx_data[DATA_W-1];
          tx_shift_d = {bus.tx_data[DATA_W-2:0], 1'b0};
          tx_cnt_d   = TxCntW'(1);
        end else if (tx_busy_q) begin
          if (tx_cnt_q == TxCntW'(DATA_W)) begin
            tx_busy_d   = 1'b0;
            tx_cnt_d    = '0;
            tx_shift_d  = '0;
            addr_rcvd_d = 1'b0;
          end else begin
            miso_d     = tx_shift_q[DATA_W-1];
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            tx_cnt_d   = tx_cnt_q + TxCntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      addr_rcvd_q <= 1'b0;
      tx_wait_q   <= 1'b0;
      tx_busy_q   <= 1'b0;
      tx_shift_q  <= '0;
      tx_cnt_q    <= '0;
      miso_q      <= 1'b0;
`ifdef SPI_PARITY_EN
      rx_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      addr_rcvd_q <= addr_rcvd_d;
      tx_wait_q   <= tx_wait_d;
      tx_busy_q   <= tx_busy_d;
      tx_shift_q  <= tx_shift_d;
      tx_cnt_q    <= tx_cnt_d;
      miso_q      <= miso_d;
`ifdef SPI_PARITY_EN
      rx_err_q    <= rx_err_d;
`endif
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
`ifdef SPI_PARITY_EN
  assign bus.rx_err   = rx_err_q;
`else
  assign bus.rx_err   = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_param.sv
// Randomized bench for spi_slave_param against a frame-level reference model.
module tb_spi_slave_param;
  localparam int DATA_W = 8;
  localparam int FW     = DATA_W + 2;
`ifdef SPI_PARITY_EN
  localparam int PAR = 1;
  localparam logic [63:0] WrVmask = 64'h1000;
`else
  localparam int PAR = 0;
  localparam logic [63:0] WrVmask = 64'h800;
`endif
  localparam int L  = 1 + FW + PAR;  // edge index (select edge = 0) completing a frame
  localparam int WR = 0;
  localparam int RA = 1;
  localparam int RD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_slave_param_if #(.DATA_W(DATA_W)) bus ();
  spi_slave_param #(.DATA_W(DATA_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  logic          exp_miso, exp_valid, exp_err;
  logic [FW-1:0] exp_data;
  logic          m_addr;
  logic [FW-1:0] m_data;
  logic [63:0]   vmask, mmask, emask;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (chk_en) begin
        check("miso", 64'(bus.MISO), 64'(exp_miso));
        check("rx_valid", 64'(bus.rx_valid), 64'(exp_valid));
        check("rx_err", 64'(bus.rx_err), 64'(exp_err));
        check("rx_data", 64'(bus.rx_data), 64'(exp_data));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic set_idle_exp();
    exp_miso  = 1'b0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_data  = m_data;
  endtask

  task automatic step(input logic ss, input logic mosi, input logic txv,
                      input logic [DATA_W-1:0] txd);
    @(negedge clk);
    bus.SS_n     = ss;
    bus.MOSI     = mosi;
    bus.tx_valid = txv;
    bus.tx_data  = txd;
    @(posedge clk);
    #1;
    set_idle_exp();
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    bus.SS_n     = 1'b1;
    bus.tx_valid = 1'b0;
    rst_n        = 1'b0;
    m_addr       = 1'b0;
    m_data       = '0;
    set_idle_exp();
    #1;
    check("rst_miso", 64'(bus.MISO), 64'(0));
    check("rst_valid", 64'(bus.rx_valid), 64'(0));
    check("rst_err", 64'(bus.rx_err), 64'(0));
    check("rst_data", 64'(bus.rx_data), 64'(0));
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // abort_j>0: SS_n high at that edge; else SS_n high at L+tail. tx_delay<0: no tx_valid.
  task automatic run_frame(input logic cmd, input logic [FW-1:0] bits, input logic par_bad,
                           input int abort_j, input int tail, input int tx_delay,
                           input logic [DATA_W-1:0] txd, input int gap, input int rst_j);
    int mode, end_e, acc;
    logic ok, pbit, mosi, txv;
    logic [DATA_W-1:0] tdat;
    mode  = !cmd ? WR : (m_addr ? RD : RA);
    ok    = (PAR == 0) || !par_bad;
    pbit  = ~(^bits) ^ par_bad;
    end_e = (abort_j > 0) ? abort_j : L + tail;
    acc   = (tx_delay >= 0) ? L + 1 + tx_delay : -1;
    vmask = '0;
    mmask = '0;
    emask = '0;
    for (int j = 0; j <= end_e; j++) begin
      if (j == 1) mosi = cmd;
      else if (j >= 2 && j < 2 + FW) mosi = bits[FW-1-(j-2)];
      else if (PAR == 1 && j == L) mosi = pbit;
      else mosi = 1'($urandom);
      if (mode == RD && ok && j > L && j == acc) begin
        txv  = 1'b1;
        tdat = txd;
      end else if (mode == RD && ok && j > L && (acc < 0 || j < acc)) begin
        txv  = 1'b0;
        tdat = DATA_W'($urandom);
      end else begin
        txv  = 1'($urandom);
        tdat = DATA_W'($urandom);
      end
      if (j == rst_j) begin
        do_reset(2);
        return;
      end
      step(j == end_e, mosi, txv, tdat);
      if (j == L) begin
        if (ok) begin
          exp_valid = 1'b1;
          m_data    = bits;
          exp_data  = bits;
          if (mode == RA) m_addr = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
      end
      if (mode == RD && ok && acc > 0 && j >= acc && j < end_e) begin
        if (j < acc + DATA_W) exp_miso = txd[DATA_W-1-(j-acc)];
        else if (j == acc + DATA_W) m_addr = 1'b0;
      end
      #1;
      vmask[j] = bus.rx_valid;
      mmask[j] = bus.MISO;
      emask[j] = bus.rx_err;
    end
    repeat (gap) step(1'b1, 1'($urandom), 1'($urandom), DATA_W'($urandom));
  endtask

  initial begin
    logic [7:0] mb;
    logic       r_cmd, r_pb;
    int         r_abort, r_tail, r_txd, r_gap;

    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    do_reset(2);
    chk_en = 1'b1;

    // Plain write frame, SS_n released at edge L+2.
    run_frame(1'b0, 10'h0A5, 1'b0, 0, 2, -1, 8'h00, 1, -1);
    check("wr_data", 64'(bus.rx_data), 64'h0A5);
    check("wr_valid_edge", vmask, WrVmask);

    // Address frame then data frame with transmit of 0xC3.
    run_frame(1'b1, 10'h203, 1'b0, 0, 2, -1, 8'h00, 1, -1);
    check("ra_data", 64'(bus.rx_data), 64'h203);
    check("model_addr_set", 64'(m_addr), 64'(1));
    run_frame(1'b1, 10'h35A, 1'b0, 0, DATA_W + 4, 1, 8'hC3, 1, -1);
    for (int k = 0; k < 8; k++) mb[7-k] = mmask[L+2+k];
    check("rd_miso_bits", 64'(mb), 64'hC3);
    check("rd_miso_after", 64'(mmask[L+2+8]), 64'(0));
    check("model_addr_clr", 64'(m_addr), 64'(0));

    // Next read-command frame must be an address frame again: no MISO activity.
    run_frame(1'b1, 10'h2F0, 1'b0, 0, DATA_W + 4, 0, 8'hFF, 1, -1);
    check("ra_again_miso", mmask, 64'h0);

    // Abort after five write bits, then a full write.
    run_frame(1'b0, 10'h0FF, 1'b0, 7, 0, -1, 8'h00, 1, -1);
    check("abort_valid", vmask, 64'h0);
    check("abort_data", 64'(bus.rx_data), 64'h2F0);
    run_frame(1'b0, 10'h15A, 1'b0, 0, 3, -1, 8'h00, 2, -1);
    check("post_abort_data", 64'(bus.rx_data), 64'h15A);

    // Reset in the middle of a transmit (address flag is set from the 0x2F0 frame).
    run_frame(1'b1, 10'h3C3, 1'b0, 0, DATA_W + 6, 0, 8'hA5, 1, L + 5);
    run_frame(1'b1, 10'h2AA, 1'b0, 0, DATA_W + 4, 0, 8'h81, 1, -1);
    check("post_rst_ra_miso", mmask, 64'h0);
    check("post_rst_ra_data", 64'(bus.rx_data), 64'h2AA);

    // SS_n rising together with the last bit still completes the frame.
    run_frame(1'b0, 10'h0C3, 1'b0, 0, 0, -1, 8'h00, 0, -1);
    check("edge_valid", vmask, WrVmask);
    check("edge_data", 64'(bus.rx_data), 64'h0C3);

`ifdef SPI_PARITY_EN
    run_frame(1'b0, 10'h0A5, 1'b1, 0, 2, -1, 8'h00, 1, -1);
    check("par_bad_err", emask, 64'h1000);
    check("par_bad_valid", vmask, 64'h0);
    check("par_bad_data", 64'(bus.rx_data), 64'h0C3);
    run_frame(1'b0, 10'h0A5, 1'b0, 0, 2, -1, 8'h00, 1, -1);
    check("par_ok_data", 64'(bus.rx_data), 64'h0A5);
    check("par_ok_err", emask, 64'h0);
`endif

    for (int n = 0; n < 300; n++) begin
      r_cmd   = ($urandom_range(0, 2) != 0);
      r_pb    = (PAR == 1) && ($urandom_range(0, 3) == 0);
      r_abort = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, L - 1)) : 0;
      r_tail  = int'($urandom_range(0, 14));
      r_txd   = int'($urandom_range(0, 5)) - 1;
      r_gap   = int'($urandom_range(0, 3));
      run_frame(r_cmd, FW'($urandom), r_pb, r_abort, r_tail, r_txd, DATA_W'($urandom),
                r_gap, -1);
      if (n == 150) do_reset(1);
    end

    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving payload bits per frame (legal range 4..32).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port SS_n, input, 1, the active-low slave select from the master.
REQ-005 The block SHALL have port MOSI, input, 1, serial data from the master, MSB first.
REQ-006 The block SHALL have port MISO, output, 1, serial read data to the master, MSB first.
REQ-007 The block SHALL have port rx_data, output, DATA_W+2, the received {cmd[1:0], payload}.
REQ-008 The block SHALL have port rx_valid, output, 1, a one-cycle pulse marking rx_data valid.
REQ-009 The block SHALL have port tx_data, input, DATA_W, the read data from the memory side.
REQ-010 The block SHALL have port tx_valid, input, 1, qualifying tx_data.
REQ-011 The block SHALL have port rx_err, output, 1, a one-cycle frame-error pulse (see Configuration).

Function
REQ-012 The FSM SHALL have states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA and no others.
REQ-013 IDLE SHALL go to CHK_CMD on the cycle SS_n is sampled low, and otherwise stay in IDLE.
REQ-014 CHK_CMD SHALL decode the sampled MOSI: 0 goes to WRITE; 1 with addr_rcvd=0 goes to READ_ADD; 1 with addr_rcvd=1 goes to READ_DATA; SS_n high goes to IDLE.
REQ-015 WRITE, READ_ADD and READ_DATA SHALL shift MOSI into a DATA_W+2-bit register, one bit per cycle, using a counter that starts at 0 on entry.
REQ-016 The cycle after the last bit is shifted, the block SHALL load rx_data and pulse rx_valid for exactly one cycle; a full frame is 1 (CHK_CMD) + DATA_W+2 bits.
REQ-017 rx_data SHALL hold its value between rx_valid pulses.
REQ-018 A completed READ_ADD frame SHALL set addr_rcvd; a completed READ_DATA transmit SHALL clear it; WRITE SHALL leave it unchanged.
REQ-019 In READ_DATA, after rx_valid, the block SHALL wait for tx_valid=1, latch tx_data in that cycle, then drive DATA_W bits on MISO on consecutive cycles, MSB first.
REQ-020 tx_valid SHALL be ignored outside the READ_DATA wait window.
REQ-021 MISO SHALL be 0 in every state other than READ_DATA and after the last transmitted bit.
REQ-022 SS_n high in WRITE, READ_ADD or READ_DATA SHALL force IDLE on the next cycle, whether the frame is complete or not.
REQ-023 On an abort, the block SHALL clear the counter, raise no rx_valid, leave rx_data stable and addr_rcvd unchanged, drive MISO to 0, and drop any pending transmit.
REQ-024 With SS_n high for two or more consecutive cycles, rx_data SHALL NOT change.
REQ-025 If SS_n rises in the same cycle as the last bit, the frame SHALL count as complete and rx_valid SHALL still pulse.

Reset
REQ-026 While rst_n=0, the block SHALL hold the FSM in IDLE, with MISO=0, rx_valid=0, rx_err=0, rx_data=0, addr_rcvd=0, counter=0 and the tx shift register=0.
REQ-027 Reset asserted mid-frame SHALL take effect immediately with no pulse, and the first frame after release SHALL decode as a fresh transaction.

Configuration
REQ-028 With macro SPI_PARITY_EN defined, each receive frame SHALL carry one extra odd-parity bit after the DATA_W+2 data bits, and rx_valid SHALL be delayed by one cycle.
REQ-029 With SPI_PARITY_EN defined and a parity mismatch, the block SHALL pulse rx_err instead of rx_valid, leave rx_data unchanged, not update addr_rcvd, and skip the READ_DATA transmit.
REQ-030 With SPI_PARITY_EN undefined, the frame SHALL be DATA_W+2 bits and rx_err SHALL be tied to 0.

Verification (DATA_W=8, macro off unless stated)
REQ-031 Write: SS_n falls, MOSI 0 then 00_1010_0101, SS_n rises at cycle 13 -> rx_data=0x0A5, rx_valid=1 at cycle 11 only, FSM back in IDLE at cycle 14.
REQ-032 Read pair: READ_ADD frame 10_0000_0011, then READ_DATA frame 11_xxxx_xxxx, tx_valid=1 with tx_data=0xC3 one cycle after rx_valid -> MISO=1,1,0,0,0,0,1,1 on consecutive cycles, then MISO=0 and addr_rcvd=0.
REQ-033 Abort: SS_n rises after 5 WRITE bits -> no rx_valid, rx_data unchanged, IDLE the next cycle; a following full write frame is decoded correctly.
REQ-034 Reset mid-READ_DATA transmit: rst_n low for 2 cycles -> MISO=0, rx_valid=0, addr_rcvd=0 immediately; the next frame starting with 1 goes to READ_ADD.
REQ-035 SPI_PARITY_EN defined: write frame 00_1010_0101 with parity bit 0 (wrong) -> rx_err pulse, no rx_valid; the same frame with parity 1 -> rx_valid with rx_data=0x0A5.
